// File: rtl/mem_stage.sv
// Memory-access stage: stalling request/acknowledge transaction with a multi-cycle
// data memory, registered writeback value, and a sticky error for bad or timed-out accesses.
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [15:0] Addr,
    input  logic [15:0] WrData,
    input  logic [15:0] MemDataIn,
    input  logic        MemAck,
    output logic        MemReq,
    output logic        MemWr,
    output logic [15:0] MemAddr,
    output logic [15:0] MemDataOut,
    output logic        Stall,
    output logic        WbValid,
    output logic [15:0] WbData,
    output logic        Err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    stateT       state;
    stateT       stateNext;
    logic [7:0]  waitCnt;
    logic        isRead;

    logic        legalOp;
    logic        illegalOp;
    logic        startReq;
    logic        ackDone;
    logic        timedOut;
    logic        passThru;

    assign legalOp   = Valid & (MemRead ^ MemWrite) & ~Addr[0];
    assign illegalOp = Valid & (MemRead | MemWrite) & ~legalOp;

    always_comb begin
        stateNext = state;
        Stall     = 1'b0;
        startReq  = 1'b0;
        ackDone   = 1'b0;
        timedOut  = 1'b0;
        passThru  = 1'b0;
        if (Err) begin
            Stall     = 1'b1;
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (legalOp) begin
                        Stall     = 1'b1;
                        startReq  = 1'b1;
                        stateNext = BUSY;
                    end else if (illegalOp) begin
                        Stall = 1'b1;
                    end else if (Valid) begin
                        passThru = 1'b1;
                    end
                end
                BUSY: begin
                    Stall = 1'b1;
                    if (MemAck) begin
                        ackDone   = 1'b1;
                        stateNext = DONE;
                    end else if (waitCnt == CntLast) begin
                        timedOut  = 1'b1;
                        stateNext = IDLE;
                    end
                end
                DONE: begin
                    stateNext = IDLE;
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
        // Reset overrides everything so upstream is never frozen while Rst is high
        if (Rst) begin
            Stall = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            waitCnt    <= '0;
            isRead     <= 1'b0;
            MemReq     <= 1'b0;
            MemWr      <= 1'b0;
            MemAddr    <= '0;
            MemDataOut <= '0;
            WbValid    <= 1'b0;
            WbData     <= '0;
            Err        <= 1'b0;
        end else begin
            WbValid <= 1'b0;
            if (startReq) begin
                MemReq     <= 1'b1;
                MemWr      <= MemWrite;
                MemAddr    <= Addr;
                MemDataOut <= WrData;
                isRead     <= MemRead;
                waitCnt    <= '0;
            end
            if (state == IDLE && !Err && illegalOp) begin
                Err <= 1'b1;
            end
            if (passThru) begin
                WbValid <= 1'b1;
                WbData  <= Addr;
            end
            // MemAddr doubles as the captured address for store writeback
            if (ackDone) begin
                MemReq  <= 1'b0;
                WbValid <= 1'b1;
                WbData  <= isRead ? MemDataIn : MemAddr;
            end else if (timedOut) begin
                MemReq <= 1'b0;
                Err    <= 1'b1;
            end else if (state == BUSY && !Err) begin
                waitCnt <= waitCnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with TIMEOUT=4.
module tb_mem_stage;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Valid;
    logic        MemRead;
    logic        MemWrite;
    logic [15:0] Addr;
    logic [15:0] WrData;
    logic [15:0] MemDataIn;
    logic        MemAck;
    logic        MemReq;
    logic        MemWr;
    logic [15:0] MemAddr;
    logic [15:0] MemDataOut;
    logic        Stall;
    logic        WbValid;
    logic [15:0] WbData;
    logic        Err;

    int unsigned total  = 0;
    int unsigned passed = 0;

    mem_stage #(.TIMEOUT(4)) dut (
        .Clk(Clk), .Rst(Rst), .Valid(Valid), .MemRead(MemRead), .MemWrite(MemWrite),
        .Addr(Addr), .WrData(WrData), .MemDataIn(MemDataIn), .MemAck(MemAck),
        .MemReq(MemReq), .MemWr(MemWr), .MemAddr(MemAddr), .MemDataOut(MemDataOut),
        .Stall(Stall), .WbValid(WbValid), .WbData(WbData), .Err(Err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic ctl(input string tag, input logic req, input logic stl, input logic wbv,
                       input logic err);
        chk({tag, ".MemReq"}, {15'd0, MemReq}, {15'd0, req});
        chk({tag, ".Stall"}, {15'd0, Stall}, {15'd0, stl});
        chk({tag, ".WbValid"}, {15'd0, WbValid}, {15'd0, wbv});
        chk({tag, ".Err"}, {15'd0, Err}, {15'd0, err});
    endtask

    // Advance to the next cycle; inputs change at +1, checks run at +2.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idleIn();
        Valid = 0; MemRead = 0; MemWrite = 0; MemAck = 0;
    endtask

    task automatic resetAll(input string tag);
        Rst = 1; idleIn();
        #1 chk({tag, ".StallInRst"}, {15'd0, Stall}, 16'd0);
        step();
        Rst = 0;
        #1;
        ctl(tag, 0, 0, 0, 0);
        chk({tag, ".MemWr"}, {15'd0, MemWr}, 16'd0);
        chk({tag, ".MemAddr"}, MemAddr, 16'h0000);
        chk({tag, ".MemDataOut"}, MemDataOut, 16'h0000);
        chk({tag, ".WbData"}, WbData, 16'h0000);
    endtask

    initial begin
        Rst = 1; idleIn(); Addr = 0; WrData = 0; MemDataIn = 0;
        step();
        resetAll("reset");

        // Non-memory op
        step(); Valid = 1; Addr = 16'h1234;
        #1 ctl("alu.p", 0, 0, 0, 0);
        step(); Valid = 0;
        #1 ctl("alu.wb", 0, 0, 1, 0);
        chk("alu.WbData", WbData, 16'h1234);
        step();
        #1 ctl("alu.after", 0, 0, 0, 0);

        // MemAck outside BUSY is ignored
        step(); MemAck = 1; MemDataIn = 16'hDEAD;
        #1 ctl("strayAck", 0, 0, 0, 0);
        step(); MemAck = 0;
        #1 ctl("strayAck.next", 0, 0, 0, 0);

        // Load 0x0040, ack on 3rd BUSY cycle
        step(); Valid = 1; MemRead = 1; Addr = 16'h0040;
        #1 ctl("ld.p", 0, 1, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            if (i == 3) begin MemAck = 1; MemDataIn = 16'hBEEF; end
            #1 ctl($sformatf("ld.busy%0d", i), 1, 1, 0, 0);
            chk("ld.MemWr", {15'd0, MemWr}, 16'd0);
            chk("ld.MemAddr", MemAddr, 16'h0040);
        end
        step(); MemAck = 0;
        #1 ctl("ld.done", 0, 0, 1, 0);
        chk("ld.WbData", WbData, 16'hBEEF);
        step(); idleIn();
        #1 ctl("ld.after", 0, 0, 0, 0);
        chk("ld.MemAddrHeld", MemAddr, 16'h0040);

        // Store 0x0010 <- 0x5A5A, ack on 1st BUSY cycle
        step(); Valid = 1; MemWrite = 1; Addr = 16'h0010; WrData = 16'h5A5A;
        #1 ctl("st.p", 0, 1, 0, 0);
        step(); MemAck = 1; MemDataIn = 16'h7777;
        #1 ctl("st.busy1", 1, 1, 0, 0);
        chk("st.MemWr", {15'd0, MemWr}, 16'd1);
        chk("st.MemDataOut", MemDataOut, 16'h5A5A);
        step(); MemAck = 0;
        #1 ctl("st.done", 0, 0, 1, 0);
        chk("st.WbData", WbData, 16'h0010);
        step(); idleIn();
        #1 ctl("st.after", 0, 0, 0, 0);

        // Ack on the last allowed BUSY cycle wins over timeout
        step(); Valid = 1; MemRead = 1; Addr = 16'h0100;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i == 4) begin MemAck = 1; MemDataIn = 16'hCAFE; end
            #1 ctl($sformatf("edge.busy%0d", i), 1, 1, 0, 0);
        end
        step(); MemAck = 0;
        #1 ctl("edge.done", 0, 0, 1, 0);
        chk("edge.WbData", WbData, 16'hCAFE);
        step(); idleIn();

        // Timeout: MemReq high exactly 4 cycles, then sticky Err
        step(); Valid = 1; MemRead = 1; Addr = 16'h0200;
        #1 ctl("to.p", 0, 1, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            #1 ctl($sformatf("to.busy%0d", i), 1, 1, 0, 0);
        end
        step(); idleIn();
        #1 ctl("to.err", 0, 1, 0, 1);
        step(); Valid = 1; Addr = 16'h0300;
        #1 ctl("to.held", 0, 1, 0, 1);
        step();
        #1 ctl("to.held2", 0, 1, 0, 1);
        resetAll("to.rst");

        // Misaligned load
        step(); Valid = 1; MemRead = 1; Addr = 16'h0041;
        step(); idleIn();
        #1 ctl("odd.err", 0, 1, 0, 1);
        step(); Valid = 1; Addr = 16'h0050;
        #1 ctl("odd.held", 0, 1, 0, 1);
        resetAll("odd.rst");

        // Both read and write at even address
        step(); Valid = 1; MemRead = 1; MemWrite = 1; Addr = 16'h0044;
        step(); idleIn();
        #1 ctl("both.err", 0, 1, 0, 1);
        step();
        #1 ctl("both.held", 0, 1, 0, 1);
        resetAll("both.rst");

        // Reset in 2nd BUSY cycle, late MemAck ignored
        step(); Valid = 1; MemRead = 1; Addr = 16'h0080;
        step();
        #1 ctl("abort.busy1", 1, 1, 0, 0);
        step(); Rst = 1;
        #1 chk("abort.StallInRst", {15'd0, Stall}, 16'd0);
        step(); Rst = 0; idleIn(); MemAck = 1; MemDataIn = 16'h1111;
        #1 ctl("abort.after", 0, 0, 0, 0);
        step(); MemAck = 0;
        #1 ctl("abort.after2", 0, 0, 0, 0);
        step(); Valid = 1; Addr = 16'h0ABC;
        #1 ctl("abort.alu.p", 0, 0, 0, 0);
        step(); Valid = 0;
        #1 ctl("abort.alu.wb", 0, 0, 1, 0);
        chk("abort.alu.WbData", WbData, 16'h0ABC);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 16-bit pipelined processor, directly downstream of the execute stage. It takes the execute result (effective address or ALU result) and store data, runs a stalling request/acknowledge transaction with a multi-cycle data memory, and presents a registered writeback value to the writeback stage. It stalls upstream while an access is outstanding and flags misaligned, illegal or timed-out accesses through a sticky error that halts the pipeline.

## Interface
- TIMEOUT, 255: maximum BUSY cycles without MemAck before an error; range 1..255.
- Clk  in  1  clock; all state changes on rising edge
- Rst  in  1  synchronous, active-high reset
- Valid  in  1  instruction present in this stage
- MemRead  in  1  instruction is a load
- MemWrite  in  1  instruction is a store
- Addr  in  16  execute-stage Output: effective address, or ALU result for non-memory ops
- WrData  in  16  store data (Reg2 value)
- MemDataIn  in  16  read data from memory; valid when MemAck=1
- MemAck  in  1  memory completion pulse; meaningful only in BUSY
- MemReq  out  1  access request; registered
- MemWr  out  1  1 = write, 0 = read; valid with MemReq
- MemAddr  out  16  registered access address
- MemDataOut  out  16  registered store data
- Stall  out  1  hold upstream stages and this stage's inputs
- WbValid  out  1  WbData valid for writeback; registered, one-cycle pulse per instruction
- WbData  out  16  load data (loads) or Addr (all other ops); registered
- Err  out  1  sticky access error

## Operation
- States: IDLE, BUSY, DONE. Internal 8-bit wait counter. Captured-op registers: IsRead, Addr, WrData.
- Legal memory op: Valid & (MemRead ^ MemWrite) & ~Addr[0]. Illegal memory op: Valid & (MemRead | MemWrite) & ~legal. This covers both-set and odd address.
- IDLE, Err=0:
  - Not Valid: WbValid<=0.
  - Valid non-memory op: Stall=0; WbValid<=1, WbData<=Addr; stay IDLE.
  - Legal memory op: Stall=1 (combinational). Capture Addr/WrData/IsRead. MemReq<=1, MemWr<=MemWrite, MemAddr<=Addr, MemDataOut<=WrData. Counter<=0. Go to BUSY. WbValid<=0.
  - Illegal memory op: no request; Err<=1; WbValid<=0; stay IDLE.
- BUSY: Stall=1.
  - MemAck=1: MemReq<=0. WbValid<=1. WbData<=MemDataIn if IsRead, else captured Addr. Go to DONE.
  - MemAck=0 and Counter==TIMEOUT-1: MemReq<=0, Err<=1, WbValid<=0, go to IDLE.
  - Otherwise: Counter<=Counter+1.
- DONE: Stall=0. The inputs still show the completed instruction and are ignored. WbValid<=0. Go to IDLE unconditionally.
- Err=1: Stall=1 in every state, no new requests, WbValid held 0. Cleared only by Rst.
- MemAck outside BUSY is ignored. MemAddr, MemDataOut and MemWr hold their last values when MemReq=0.

## Timing
- Reset, effective at the edge with Rst=1: state IDLE, counter 0, MemReq=0, MemWr=0, MemAddr=0x0000, MemDataOut=0x0000, WbValid=0, WbData=0x0000, Err=0. Stall is forced 0 while Rst=1.
- Rst in BUSY or DONE aborts the access. MemReq=0 from the next cycle; a later MemAck is ignored.
- Non-memory op: WbValid/WbData one cycle after presentation; no stall.
- Memory op with MemAck on BUSY cycle k (k=1 for the first BUSY cycle):
  - Stall is high for 1+k cycles.
  - MemReq is high for k cycles.
  - WbValid pulses in the DONE cycle, 1+k cycles after presentation.
  - Upstream advances at the end of DONE.
- Timeout: MemReq high exactly TIMEOUT cycles. Err rises the cycle after the last of those cycles.
- Back-to-back memory ops: minimum 2+k cycles each (IDLE, k BUSY, DONE). There is no bypass from DONE to a new request.

## Test plan
- Non-memory op: Valid=1, Addr=0x1234, MemRead=MemWrite=0 -> Stall stays 0; next cycle WbValid=1, WbData=0x1234; the cycle after, WbValid=0.
- Load Addr=0x0040, MemAck on 3rd BUSY cycle with MemDataIn=0xBEEF:
  - MemReq=1, MemWr=0, MemAddr=0x0040 for 3 cycles.
  - Stall high 4 cycles.
  - WbData=0xBEEF with a single-cycle WbValid.
- Store Addr=0x0010, WrData=0x5A5A, MemAck on 1st BUSY cycle:
  - MemReq, MemWr=1, MemDataOut=0x5A5A for 1 cycle.
  - WbValid pulse with WbData=0x0010.
  - Stall high 2 cycles.
- Misaligned load Addr=0x0041 -> MemReq never asserts; Err=1 next cycle; Stall=1 until Rst. Repeat with MemRead=MemWrite=1 at an even address -> same result.
- TIMEOUT=4, load with MemAck never asserted -> MemReq high exactly 4 cycles; Err=1; Stall held 1. Then pulse Rst -> all outputs return to reset values.
- Rst asserted in 2nd BUSY cycle, MemAck pulsed the cycle after -> MemReq=0 after the reset edge; no WbValid pulse; Err=0; next non-memory op completes normally.
